// File: rtl/program_loader.sv
// Byte-stream program loader: LEN, then HI/LO byte pairs written as 16-bit words.
// Optional trailer checksum enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_run
);

  // Count must hold the full depth (N=0 means 2^ADDR_W) and any raw count byte.
  localparam int CNT_W = (ADDR_W >= 8) ? ADDR_W + 1 : 9;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_HI, S_LO, S_WRITE, S_CSUM, S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] word_total, word_cnt, len_ext, len_val;
  logic [7:0]       hi_byte;
  logic             accept, start_load, last_word;

  assign accept     = in_valid & in_ready;
  assign start_load = start & ((state == S_IDLE) | (state == S_DONE));
  assign last_word  = ((word_cnt + CNT_W'(1)) == word_total);

  always_comb begin
    len_ext = CNT_W'(in_data);
    if (in_data == 8'd0 || len_ext > DEPTH)
      len_val = DEPTH;
    else
      len_val = len_ext;
  end

  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_n = S_LEN;
      end
      S_LEN: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_HI;
      end
      S_HI: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_LO;
      end
      S_LO: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_WRITE;
      end
      S_WRITE: begin
        mem_we = 1'b1;
        if (last_word) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          state_n = S_CSUM;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_HI;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = S_LEN;
      end
      default: begin
        busy    = 1'b0;
        state_n = S_IDLE;
      end
    endcase
    cpu_run = done & ~error;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      word_total <= '0;
      word_cnt   <= '0;
      hi_byte    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state <= state_n;
      if (start_load) begin
        mem_addr <= '0;
        word_cnt <= '0;
      end
      if (accept && state == S_LEN) word_total <= len_val;
      if (accept && state == S_HI)  hi_byte    <= in_data;
      // Word register only updates on the LO byte so mem_wdata is stable outside WRITE.
      if (accept && state == S_LO)  mem_wdata  <= {hi_byte, in_data};
      if (state == S_WRITE) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  logic       err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (start_load) begin
      csum  <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      if (state == S_CSUM) begin
        if (in_data != csum) err_q <= 1'b1;
      end else begin
        csum <= csum ^ in_data;
      end
    end
  end

  assign error = err_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: byte-stream model predicts every memory write
// (cycle, address, data) and the final done/error/cpu_run status of each load.
module tb_program_loader;
  localparam int AW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, mem_we, busy, done, error, cpu_run;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;

  program_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .done(done), .error(error), .cpu_run(cpu_run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            due;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  logic [7:0]    bq[$];
  int            vectors = 0, miscompares = 0, cyc = 0, wr_seen = 0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic [15:0]   first_data = '0, last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every write strobe must match the head of the predicted write queue exactly.
  initial begin : compare
    wr_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_we === 1'b1) begin
        if (wr_seen == 0) begin
          first_addr = mem_addr;
          first_data = mem_wdata;
        end
        last_addr = mem_addr;
        last_data = mem_wdata;
        wr_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL spurious_we: got write %0h<=%0h expected none (t=%0t)", mem_addr, mem_wdata, $time);
        end else begin
          e = exp_q[0];
          exp_q.delete(0);
          check("we_cycle", cyc, e.due);
          check("we_addr", mem_addr, e.addr);
          check("we_data", mem_wdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL we_missing: got no write expected %0h<=%0h (t=%0t)", exp_q[0].addr, exp_q[0].data, $time);
        exp_q.delete(0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
      @(posedge clk);
    end
    #1;
    in_valid = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic pulse_start();
    wr_seen = 0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_ready", in_ready, 1);
    check("start_done", done, 0);
    check("start_cpu_run", cpu_run, 0);
    check("start_error", error, 0);
    check("start_addr", mem_addr, 0);
  endtask

  task automatic add_trailer();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = '0;
    foreach (bq[i]) x ^= bq[i];
    bq.push_back(x);
`endif
  endtask

  task automatic do_load(input int stall_before);
    int            n;
    logic [7:0]    x, hi;
    logic [AW-1:0] a;
    logic [15:0]   lastw;
    bit            ok, exp_err;
    pulse_start();
    n = (bq[0] == 8'd0) ? DEPTH : int'(bq[0]);
    x = '0; hi = '0; a = '0; lastw = '0; exp_err = 1'b0;
    for (int k = 0; k < bq.size(); k++) begin
      if (k == stall_before) begin
        for (int i = 0; i < 5; i++) begin
          in_data = 8'($urandom);
          start   = (i == 2);
          @(posedge clk);
          #1;
        end
        start = 1'b0;
      end
      send_byte(bq[k], ok);
      if (k <= 2 * n) x ^= bq[k];
      else exp_err = (bq[k] != x);
      if (k > 0 && k <= 2 * n) begin
        if (k % 2 == 1) begin
          hi = bq[k];
        end else begin
          lastw = {hi, bq[k]};
          exp_q.push_back('{cyc + 1, a, lastw});
          a++;
        end
      end
    end
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_timeout", ok, 1);
    check("end_done", done, 1);
    check("end_error", error, exp_err);
    check("end_cpu_run", cpu_run, !exp_err);
    check("end_busy", busy, 0);
    check("end_ready", in_ready, 0);
    check("end_addr", mem_addr, a);
    check("end_wdata", mem_wdata, lastw);
    check("pending_writes", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_sticky", done, 1);
    check("cpu_run_sticky", cpu_run, !exp_err);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 0);
    check("rst_we", mem_we, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cpu_run", cpu_run, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    #3;
    reset = 1'b1;

    // Bytes without start must not move the block.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(i * 17 + 2);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    bq = {8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    add_trailer();
    do_load(-1);
    check("pin_first_addr", first_addr, 0);
    check("pin_first_data", first_data, 16'h1234);
    check("pin_last_addr", last_addr, 1);
    check("pin_last_data", last_data, 16'hABCD);
    check("pin_wr_count", wr_seen, 2);

    bq = {8'h01, 8'h56, 8'h78};
    add_trailer();
    do_load(2);
    check("pin_stall_data", first_data, 16'h5678);
    check("pin_stall_count", wr_seen, 1);

    bq.delete();
    bq.push_back(8'h00);
    for (int i = 0; i < 512; i++) bq.push_back(8'(i * 37 + 5));
    add_trailer();
    do_load(-1);
    check("pin_full_count", wr_seen, 256);
    check("pin_full_first", first_addr, 0);
    check("pin_full_last", last_addr, 8'hFF);
    check("pin_full_wrap", mem_addr, 0);

    // Abort a load by reset after the HI byte of word 1.
    bq = {8'h03, 8'h11, 8'h22, 8'h33};
    pulse_start();
    send_byte(bq[0], ok);
    send_byte(bq[1], ok);
    send_byte(bq[2], ok);
    exp_q.push_back('{cyc + 1, AW'(0), 16'h1122});
    send_byte(bq[3], ok);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ready", in_ready, 0);
    check("abort_we", mem_we, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_error", error, 0);
    check("abort_cpu_run", cpu_run, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_wdata", mem_wdata, 0);
    check("abort_wr_count", wr_seen, 1);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i * 29 + 1);
      @(negedge clk);
      check("post_abort_busy", busy, 0);
      check("post_abort_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_abort_wr_count", wr_seen, 1);

    bq = {8'h01, 8'hBE, 8'hEF};
    add_trailer();
    do_load(-1);
    check("pin_reload_addr", first_addr, 0);
    check("pin_reload_data", first_data, 16'hBEEF);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    bq = {8'h01, 8'h12, 8'h34, 8'h27};
    do_load(-1);
    check("pin_csum_ok_error", error, 0);
    check("pin_csum_ok_run", cpu_run, 1);
    bq = {8'h01, 8'h12, 8'h34, 8'h00};
    do_load(-1);
    check("pin_csum_bad_error", error, 1);
    check("pin_csum_bad_run", cpu_run, 0);
`endif

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
